// File: rtl/gen_pkg.sv
// Shared types and constants for the gen_skid_buf elastic pipeline register.
package gen_pkg;

    // Occupancy states; the encoding doubles as the level output.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_BUSY  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/gen_skid_buf.sv
// gen_skid_buf: two-entry skid buffer between stall-able pipeline stages.
// main_q always holds the oldest beat and drives m_data. skid_q catches the
// one beat that arrives while downstream stalls.
// s_ready never depends on m_ready, so upstream needs no combinational path.
// Optional build macro GEN_SKID_BUF_PROTO_CHK_EN adds a sticky proto_err
// output that flags an upstream beat withdrawn or altered while stalled.
module gen_skid_buf
    import gen_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic [DW-1:0]                        def_val,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [DW-1:0]                        s_data,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [DW-1:0]                        m_data,
    output logic [$clog2(SKID_DEPTH+1)-1:0]      level
`ifdef GEN_SKID_BUF_PROTO_CHK_EN
    ,
    output logic                                 proto_err
`endif
);

    skid_state_e   state_q, state_d;
    logic [DW-1:0] main_q, main_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          s_fire;
    logic          m_fire;

    // Handshake outputs: m_valid and level come straight from the state
    // register; s_ready is gated only by FULL, flush and reset.
    always_comb begin
        m_valid = (state_q != SKID_EMPTY);
        s_ready = (state_q != SKID_FULL) & ~flush & ~rst;
        m_data  = main_q;
        level   = state_q;
        s_fire  = s_valid & s_ready;
        m_fire  = m_valid & m_ready;
    end

    // Next-state and storage update; flush discards everything and reloads
    // def_val, a downstream take in that same cycle is simply dropped here.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = SKID_EMPTY;
            main_d  = def_val;
            skid_d  = def_val;
        end else begin
            unique case (state_q)
                SKID_EMPTY: begin
                    if (s_fire) begin
                        state_d = SKID_BUSY;
                        main_d  = s_data;
                    end
                end
                SKID_BUSY: begin
                    if (s_fire && m_fire) begin
                        main_d = s_data;
                    end else if (s_fire && !m_ready) begin
                        state_d = SKID_FULL;
                        skid_d  = s_data;
                    end else if (!s_fire && m_fire) begin
                        state_d = SKID_EMPTY;
                        main_d  = def_val;
                    end
                end
                SKID_FULL: begin
                    if (m_fire) begin
                        state_d = SKID_BUSY;
                        main_d  = skid_q;
                        skid_d  = def_val;
                    end
                end
                default: begin
                    state_d = SKID_EMPTY;
                    main_d  = def_val;
                    skid_d  = def_val;
                end
            endcase
        end
    end

    // State and storage registers with synchronous reset to the NOP value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SKID_EMPTY;
            main_q  <= def_val;
            skid_q  <= def_val;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef GEN_SKID_BUF_PROTO_CHK_EN
    logic          prev_valid_q;
    logic          prev_ready_q;
    logic [DW-1:0] prev_data_q;
    logic          proto_err_q, proto_err_d;

    // A stalled beat must stay offered with identical data until accepted.
    always_comb begin
        proto_err_d = proto_err_q;
        if (flush) begin
            proto_err_d = 1'b0;
        end else if (prev_valid_q && !prev_ready_q &&
                     (!s_valid || (s_data != prev_data_q))) begin
            proto_err_d = 1'b1;
        end
    end

    // Remember last cycle's upstream offer and keep the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_valid_q <= 1'b0;
            prev_ready_q <= 1'b0;
            prev_data_q  <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            prev_valid_q <= s_valid;
            prev_ready_q <= s_ready;
            prev_data_q  <= s_data;
            proto_err_q  <= proto_err_d;
        end
    end

    assign proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_gen_skid_buf.sv
// Directed self-checking bench for gen_skid_buf.
// Inputs change 1 time unit after each rising edge and outputs are checked
// there too, well away from the next active edge.
module tb_gen_skid_buf;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [DW-1:0] def_val;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [1:0]    level;
`ifdef GEN_SKID_BUF_PROTO_CHK_EN
    logic          proto_err;
`endif

    int total = 0;
    int bad   = 0;

    gen_skid_buf #(.DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .def_val  (def_val),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .level    (level)
`ifdef GEN_SKID_BUF_PROTO_CHK_EN
        ,
        .proto_err(proto_err)
`endif
    );

    always #5 clk = ~clk;

    // Drive one cycle of upstream/downstream stimulus and advance past the edge.
    task automatic applyStimulus(input logic sv, input logic [DW-1:0] sd,
                                 input logic mr);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [DW-1:0] obs,
                               input logic [DW-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check the full handshake-side view in one call.
    task automatic checkAll(input string tag, input logic mv, input logic sr,
                            input logic [1:0] lv, input logic [DW-1:0] md);
        checkOutput({tag, ".m_valid"}, DW'(m_valid), DW'(mv));
        checkOutput({tag, ".s_ready"}, DW'(s_ready), DW'(sr));
        checkOutput({tag, ".level"},   DW'(level),   DW'(lv));
        checkOutput({tag, ".m_data"},  m_data,       md);
    endtask

    initial begin
        rst     = 1'b1;
        flush   = 1'b0;
        def_val = 32'h13;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;

        // Reset held for two edges.
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkAll("reset", 1'b0, 1'b0, 2'd0, 32'h13);
`ifdef GEN_SKID_BUF_PROTO_CHK_EN
        checkOutput("reset.proto_err", DW'(proto_err), 32'd0);
`endif
        rst = 1'b0;
        #1;
        checkOutput("postreset.s_ready", DW'(s_ready), 32'd1);

        // Streaming 1,2,3,4 with downstream always ready.
        applyStimulus(1'b1, 32'd1, 1'b1);
        checkAll("stream1", 1'b1, 1'b1, 2'd1, 32'd1);
        applyStimulus(1'b1, 32'd2, 1'b1);
        checkAll("stream2", 1'b1, 1'b1, 2'd1, 32'd2);
        applyStimulus(1'b1, 32'd3, 1'b1);
        checkAll("stream3", 1'b1, 1'b1, 2'd1, 32'd3);
        applyStimulus(1'b1, 32'd4, 1'b1);
        checkAll("stream4", 1'b1, 1'b1, 2'd1, 32'd4);
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkAll("drain", 1'b0, 1'b1, 2'd0, 32'h13);

        // Backpressure: A then B with downstream stalled.
        applyStimulus(1'b1, 32'hA, 1'b0);
        checkAll("bpA", 1'b1, 1'b1, 2'd1, 32'hA);
        applyStimulus(1'b1, 32'hB, 1'b0);
        checkAll("bpB", 1'b1, 1'b0, 2'd2, 32'hA);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkAll("bpHold", 1'b1, 1'b0, 2'd2, 32'hA);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkAll("bpOutA", 1'b1, 1'b1, 2'd1, 32'hB);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkAll("bpOutB", 1'b0, 1'b1, 2'd0, 32'h13);

        // Flush while FULL, loading a different NOP value at the flush edge.
        applyStimulus(1'b1, 32'hA, 1'b0);
        applyStimulus(1'b1, 32'hB, 1'b0);
        checkAll("preflush", 1'b1, 1'b0, 2'd2, 32'hA);
        s_valid = 1'b0;
        flush   = 1'b1;
        def_val = 32'h55;
        #1;
        checkOutput("flush.s_ready", DW'(s_ready), 32'd0);
        @(posedge clk); #1;
        flush   = 1'b0;
        def_val = 32'h13;
        #1;
        checkAll("postflush", 1'b0, 1'b1, 2'd0, 32'h55);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("defSampled.m_data", m_data, 32'h55);

        // Simultaneous accept and take while BUSY.
        applyStimulus(1'b1, 32'hA, 1'b0);
        checkAll("simA", 1'b1, 1'b1, 2'd1, 32'hA);
        applyStimulus(1'b1, 32'hC, 1'b1);
        checkAll("simC", 1'b1, 1'b1, 2'd1, 32'hC);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkAll("simDrain", 1'b0, 1'b1, 2'd0, 32'h13);

`ifdef GEN_SKID_BUF_PROTO_CHK_EN
        // Upstream changes its stalled beat 5 -> 6 while FULL.
        checkOutput("proto.clean", DW'(proto_err), 32'd0);
        applyStimulus(1'b1, 32'hA, 1'b0);
        applyStimulus(1'b1, 32'hB, 1'b0);
        applyStimulus(1'b1, 32'd5, 1'b0);
        checkOutput("proto.stall5", DW'(proto_err), 32'd0);
        applyStimulus(1'b1, 32'd6, 1'b0);
        checkOutput("proto.set", DW'(proto_err), 32'd1);
        applyStimulus(1'b0, 32'd0, 1'b0);
        checkOutput("proto.sticky", DW'(proto_err), 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checkOutput("proto.cleared", DW'(proto_err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
